// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and baud divider.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head read.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered, LSB first, optional parity,
// one or two stop bits. Line output is registered and lags the FSM by one cycle.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din_vld,
    input  logic [DATA_BITS-1:0]   din_data,
    output logic                   din_rdy,
    output logic                   dout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN ||
        DIV < 2) begin : g_bad_param
        $error("uart_tx_param: illegal parameter combination");
    end

    uart_state_t          state;
    uart_state_t          state_nx;
    logic [DW-1:0]        div_cnt;
    logic [DW-1:0]        div_nx;
    logic [2:0]           bit_idx;
    logic [2:0]           idx_nx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 line_bit;
    logic                 tail;
    logic                 bit_end;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    assign din_rdy   = rst_n & ~fifo_full;
    assign fifo_push = din_vld & din_rdy;
    assign bit_end   = (div_cnt == DIV_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (din_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        state_nx = state;
        div_nx   = '0;
        idx_nx   = bit_idx;
        fifo_pop = 1'b0;

        if (state != ST_IDLE)
            div_nx = bit_end ? '0 : div_cnt + 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_START;
                    fifo_pop = 1'b1;
                    idx_nx   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nx = ST_DATA;
                    idx_nx   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == DATA_LAST) begin
                        state_nx = HAS_PAR ? ST_PAR : ST_STOP;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = bit_idx + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_nx = ST_STOP;
                    idx_nx   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_nx = '0;
                        // Chain straight into the next start bit when more is queued.
                        if (!fifo_empty) begin
                            state_nx = ST_START;
                            fifo_pop = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        idx_nx = bit_idx + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        line_bit = 1'b1;
        unique case (state)
            ST_START: line_bit = 1'b0;
            ST_DATA:  line_bit = shreg[0];
            ST_PAR:   line_bit = par_bit;
            default:  line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            dout    <= 1'b1;
            tail    <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_idx <= idx_nx;
            if (fifo_pop) begin
                shreg   <= fifo_rdata;
                par_bit <= (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            end else if (state == ST_DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
            dout <= line_bit;
            tail <= (state != ST_IDLE);
        end
    end

    // tail covers the final registered stop-bit cycle after the FSM returns to idle.
    assign busy = (state != ST_IDLE) | ~fifo_empty | tail;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four parameterisations, scoreboarded
// expected words decoded from the serial line.
module tb_uart_tx_param;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] line;
    logic [3:0] bsy;
    logic [7:0] dat [3];
    logic [4:0] dat5;
    logic [2:0] cnt [4];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .din_vld(vld[0]), .din_data(dat[0]),
        .din_rdy(rdy[0]), .dout(line[0]), .busy(bsy[0]), .fifo_cnt(cnt[0]));

    uart_tx_param #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n), .din_vld(vld[1]), .din_data(dat[1]),
        .din_rdy(rdy[1]), .dout(line[1]), .busy(bsy[1]), .fifo_cnt(cnt[1]));

    uart_tx_param #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .din_vld(vld[2]), .din_data(dat[2]),
        .din_rdy(rdy[2]), .dout(line[2]), .busy(bsy[2]), .fifo_cnt(cnt[2]));

    uart_tx_param #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(5), .PARITY(0),
                    .STOP_BITS(2), .DEPTH(4)) u_5n2 (
        .clk(clk), .rst_n(rst_n), .din_vld(vld[3]), .din_data(dat5),
        .din_rdy(rdy[3]), .dout(line[3]), .busy(bsy[3]), .fifo_cnt(cnt[3]));

    task automatic push_word(input int ch, input logic [7:0] d, output int at);
        vld[ch] = 1'b1;
        if (ch == 3) begin
            dat5 = d[4:0];
            exp_q.push_back({3'b000, d[4:0]});
        end else begin
            dat[ch] = d;
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        vld[ch] = 1'b0;
        at = cyc;
    endtask

    // Decode one frame from line[ch], comparing against the scoreboard head.
    task automatic rx_frame(input int ch, input int nbits, input int par,
                            input int nstop, output int s_cyc, output int e_cyc);
        logic [7:0] w;
        logic [7:0] expw;
        logic       smp;
        logic       pbit;
        logic       pexp;
        int         bad;
        int         hold_err;
        bit         found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (line[ch] == 1'b0) found = 1'b1;
        end
        s_cyc = cyc;
        e_cyc = cyc;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rx_timeout ch=%0d got=no start bit want=start bit", ch);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        bad = 0;
        for (int i = 1; i < DIV; i++) begin
            @(posedge clk);
            #1;
            if (line[ch] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rx_start ch=%0d got=%0d high samples want=0", ch, bad);
        end
        w = '0;
        hold_err = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int i = 0; i < DIV; i++) begin
                @(posedge clk);
                #1;
                smp = line[ch];
                if (i == 0) w[b] = smp;
                else if (smp !== w[b]) hold_err++;
            end
        end
        expw = 8'h00;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected ch=%0d got=%h want=no frame", ch, w);
        end else begin
            expw = exp_q.pop_front();
            if (w !== expw) begin
                errors++;
                $display("FAIL rx_data ch=%0d got=%h want=%h", ch, w, expw);
            end
        end
        if (par != 0) begin
            pbit = 1'b0;
            for (int i = 0; i < DIV; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) pbit = line[ch];
                else if (line[ch] !== pbit) hold_err++;
            end
            pexp = ^expw;
            if (par == 1) pexp = ~pexp;
            checks++;
            if (pbit !== pexp) begin
                errors++;
                $display("FAIL rx_parity ch=%0d got=%b want=%b", ch, pbit, pexp);
            end
        end
        bad = 0;
        for (int i = 0; i < nstop * DIV; i++) begin
            @(posedge clk);
            #1;
            if (line[ch] !== 1'b1) bad++;
        end
        e_cyc = cyc;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rx_stop ch=%0d got=%0d low samples want=0", ch, bad);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL rx_hold ch=%0d got=%0d unstable samples want=0", ch, hold_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        vld   = '0;
        dat[0] = '0;
        dat[1] = '0;
        dat[2] = '0;
        dat5  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (line !== 4'hF || bsy !== 4'h0 || rdy !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs got dout=%b busy=%b rdy=%b want 1111/0000/0000",
                     line, bsy, rdy);
        end
        checks++;
        if (cnt[0] !== 3'd0 || cnt[1] !== 3'd0 || cnt[2] !== 3'd0 || cnt[3] !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d %0d %0d %0d want 0", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rdy !== 4'hF || line !== 4'hF) begin
            errors++;
            $display("FAIL reset_release got rdy=%b dout=%b want 1111/1111", rdy, line);
        end
    endtask

    task automatic test_8n1;
        int pc, s, e;
        fork
            push_word(0, 8'hA5, pc);
            rx_frame(0, 8, 0, 1, s, e);
        join
        checks++;
        if (s - pc != 2) begin
            errors++;
            $display("FAIL latency_8n1 got=%0d want=2", s - pc);
        end
        checks++;
        if (bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_last_stop got=%b want=1", bsy[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bsy[0] !== 1'b0 || line[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_fall got busy=%b dout=%b want 0/1", bsy[0], line[0]);
        end
    endtask

    task automatic test_parity;
        int pc, s, e;
        for (int ch = 1; ch <= 2; ch++) begin
            fork
                push_word(ch, 8'h55, pc);
                rx_frame(ch, 8, (ch == 1) ? 2 : 1, 1, s, e);
            join
            checks++;
            if (bsy[ch] !== 1'b1) begin
                errors++;
                $display("FAIL parity_len_busy ch=%0d got=%b want=1", ch, bsy[ch]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bsy[ch] !== 1'b0) begin
                errors++;
                $display("FAIL parity_len_end ch=%0d got=%b want=0", ch, bsy[ch]);
            end
        end
    endtask

    task automatic test_5n2;
        int pc, s, e;
        fork
            push_word(3, 8'h1F, pc);
            rx_frame(3, 5, 0, 2, s, e);
        join
        checks++;
        if (bsy[3] !== 1'b1) begin
            errors++;
            $display("FAIL 5n2_len_busy got=%b want=1", bsy[3]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bsy[3] !== 1'b0 || line[3] !== 1'b1) begin
            errors++;
            $display("FAIL 5n2_len_end got busy=%b dout=%b want 0/1", bsy[3], line[3]);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [6];
        int s [6];
        int e [6];
        int k, guard, maxc;
        bit dropped;
        w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h81;
        w[3] = 8'h7E; w[4] = 8'h3C; w[5] = 8'hC3;
        k = 0;
        guard = 0;
        maxc = 0;
        dropped = 1'b0;
        fork
            begin
                vld[0] = 1'b1;
                while (k < 6 && guard < 2000) begin
                    dat[0] = w[k];
                    @(negedge clk);
                    guard++;
                    if (int'(cnt[0]) > maxc) maxc = int'(cnt[0]);
                    if (rdy[0]) begin
                        exp_q.push_back(w[k]);
                        k++;
                    end else begin
                        dropped = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                end
                vld[0] = 1'b0;
            end
            begin
                for (int f = 0; f < 6; f++) rx_frame(0, 8, 0, 1, s[f], e[f]);
            end
        join
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL b2b_accepted got=%0d want=6", k);
        end
        checks++;
        if (!dropped || maxc != 4) begin
            errors++;
            $display("FAIL b2b_full got dropped=%0d maxcnt=%0d want 1/4", dropped, maxc);
        end
        for (int f = 1; f < 6; f++) begin
            checks++;
            if (s[f] != e[f-1] + 1) begin
                errors++;
                $display("FAIL b2b_gap frame=%0d got=%0d idle cycles want=0",
                         f, s[f] - e[f-1] - 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset;
        int pc, lows, busys;
        push_word(0, 8'h3C, pc);
        push_word(0, 8'hC3, pc);
        push_word(0, 8'h0F, pc);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cnt[0] !== 3'd2) begin
            errors++;
            $display("FAIL midrst_queued got=%0d want=2", cnt[0]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (line[0] !== 1'b1 || cnt[0] !== 3'd0 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got dout=%b cnt=%0d busy=%b want 1/0/0",
                     line[0], cnt[0], bsy[0]);
        end
        rst_n = 1'b1;
        exp_q.delete();
        lows = 0;
        busys = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (line[0] !== 1'b1) lows++;
            if (bsy[0] !== 1'b0) busys++;
        end
        checks++;
        if (lows != 0 || busys != 0) begin
            errors++;
            $display("FAIL midrst_residual got low=%0d busy=%0d want 0/0", lows, busys);
        end
    endtask

    task automatic test_push_pop;
        int a, tmp, s, e;
        fork
            begin
                push_word(0, 8'h11, a);
                push_word(0, 8'h22, tmp);
                push_word(0, 8'h33, tmp);
                while (cyc < a + 80) begin
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (cnt[0] !== 3'd2) begin
                    errors++;
                    $display("FAIL pushpop_before got=%0d want=2", cnt[0]);
                end
                vld[0] = 1'b1;
                dat[0] = 8'h44;
                exp_q.push_back(8'h44);
                @(posedge clk);
                #1;
                vld[0] = 1'b0;
                checks++;
                if (cnt[0] !== 3'd2) begin
                    errors++;
                    $display("FAIL pushpop_after got=%0d want=2", cnt[0]);
                end
            end
            begin
                for (int f = 0; f < 4; f++) rx_frame(0, 8, 0, 1, s, e);
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pushpop_drain got=%0d left want=0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_5n2();
        test_back_to_back();
        test_mid_reset();
        test_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
